// File: rtl/net_resolve_pkg.sv
// Shared encodings for the resolved-bus block: resolution modes and fault FSM states.
package net_resolve_pkg;

    typedef enum logic [1:0] {
        MODE_TRI  = 2'd0,
        MODE_WAND = 2'd1,
        MODE_WOR  = 2'd2
    } mode_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_e;

endpackage

// File: rtl/net_resolve_bit.sv
// Combinational resolver for one bus bit across all drivers: resolved value and conflict flag.
module net_resolve_bit
    import net_resolve_pkg::*;
#(
    parameter int N_DRV = 4,
    parameter int MODE  = 0,
    parameter int PULL  = 0
) (
    input  logic [N_DRV-1:0] en_i,
    input  logic [N_DRV-1:0] bit_i,
    output logic             res_o,
    output logic             conf_o
);

    localparam logic PULL_B = (PULL != 0);

    logic any_en;
    logic all_one;
    logic any_one;

    assign any_en  = |en_i;
    assign all_one = &(bit_i | ~en_i);
    assign any_one = |(bit_i & en_i);

    always_comb begin
        res_o  = PULL_B;
        conf_o = 1'b0;
        if (any_en) begin
            // TRI shares the AND path: disagreeing bits clear all_one and fall to 0.
            if (MODE == int'(MODE_WOR)) res_o = any_one;
            else                        res_o = all_one;
            if (MODE == int'(MODE_TRI)) conf_o = any_one & ~all_one;
        end
    end

endmodule

// File: rtl/net_resolve_bus.sv
// Multi-driver bus resolver with registered outputs, saturating conflict counter and fault FSM.
module net_resolve_bus
    import net_resolve_pkg::*;
#(
    parameter int N_DRV        = 4,
    parameter int W            = 8,
    parameter int MODE         = 0,
    parameter int PULL         = 0,
    parameter int FAULT_THRESH = 3,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_DRV-1:0]   drv_en,
    input  logic [N_DRV*W-1:0] drv_data,
    input  logic               clr_fault,
    output logic [W-1:0]       bus_out,
    output logic [W-1:0]       conflict,
    output logic               fault,
    output logic [CNT_W-1:0]   conflict_cnt
);

    localparam int          CONS_W   = (FAULT_THRESH < 2) ? 1 : $clog2(FAULT_THRESH + 1);
    localparam logic [W-1:0] PULL_VEC = (PULL != 0) ? '1 : '0;

    logic [W-1:0] res;
    logic [W-1:0] conf;
    logic         conflict_cycle;

    for (genvar b = 0; b < W; b++) begin : g_bit
        logic [N_DRV-1:0] col;
        for (genvar d = 0; d < N_DRV; d++) begin : g_drv
            assign col[d] = drv_data[d*W + b];
        end
        net_resolve_bit #(
            .N_DRV (N_DRV),
            .MODE  (MODE),
            .PULL  (PULL)
        ) u_bit (
            .en_i   (drv_en),
            .bit_i  (col),
            .res_o  (res[b]),
            .conf_o (conf[b])
        );
    end

    assign conflict_cycle = |conf;

    state_e             state_q, state_d;
    logic [W-1:0]       bus_q, bus_d;
    logic [W-1:0]       conf_q, conf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CONS_W-1:0]  consec_q, consec_d;

    always_comb begin
        state_d  = state_q;
        bus_d    = bus_q;
        conf_d   = conf;
        cnt_d    = cnt_q;
        consec_d = consec_q;

        if (conflict_cycle && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);

        case (state_q)
            ST_RUN: begin
                bus_d = res;
                if (conflict_cycle) begin
                    if (consec_q == CONS_W'(FAULT_THRESH - 1)) begin
                        state_d  = ST_FAULT;
                        consec_d = '0;
                    end else begin
                        consec_d = consec_q + CONS_W'(1);
                    end
                end else begin
                    consec_d = '0;
                end
            end
            ST_FAULT: begin
                // bus_out frozen; consecutive count held at zero so a clear restarts it.
                consec_d = '0;
                if (clr_fault) state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            bus_q    <= PULL_VEC;
            conf_q   <= '0;
            cnt_q    <= '0;
            consec_q <= '0;
        end else begin
            state_q  <= state_d;
            bus_q    <= bus_d;
            conf_q   <= conf_d;
            cnt_q    <= cnt_d;
            consec_q <= consec_d;
        end
    end

    assign bus_out      = bus_q;
    assign conflict     = conf_q;
    assign fault        = (state_q == ST_FAULT);
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_net_resolve_bus.sv
// Scoreboard bench: four parameterisations share stimulus; a behavioural model predicts each.
module tb_net_resolve_bus;

    localparam int NI     = 4;
    localparam int THRESH = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  drv_en = '0;
    logic [31:0] drv_data = '0;
    logic        clr_fault = 1'b0;

    always #5 clk = ~clk;

    logic [7:0]  bus0, bus1, bus2, bus3;
    logic [7:0]  cf0, cf1, cf2, cf3;
    logic        ft0, ft1, ft2, ft3;
    logic [15:0] cnt0, cnt1, cnt3;
    logic [3:0]  cnt2;

    net_resolve_bus #(.N_DRV(4), .W(8), .MODE(0), .PULL(0), .FAULT_THRESH(THRESH), .CNT_W(16)) u_tri (
        .clk(clk), .rst_n(rst_n), .drv_en(drv_en), .drv_data(drv_data), .clr_fault(clr_fault),
        .bus_out(bus0), .conflict(cf0), .fault(ft0), .conflict_cnt(cnt0));
    net_resolve_bus #(.N_DRV(4), .W(8), .MODE(1), .PULL(1), .FAULT_THRESH(THRESH), .CNT_W(16)) u_wand (
        .clk(clk), .rst_n(rst_n), .drv_en(drv_en), .drv_data(drv_data), .clr_fault(clr_fault),
        .bus_out(bus1), .conflict(cf1), .fault(ft1), .conflict_cnt(cnt1));
    net_resolve_bus #(.N_DRV(4), .W(8), .MODE(0), .PULL(1), .FAULT_THRESH(THRESH), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .drv_en(drv_en), .drv_data(drv_data), .clr_fault(clr_fault),
        .bus_out(bus2), .conflict(cf2), .fault(ft2), .conflict_cnt(cnt2));
    net_resolve_bus #(.N_DRV(4), .W(8), .MODE(2), .PULL(0), .FAULT_THRESH(THRESH), .CNT_W(16)) u_wor (
        .clk(clk), .rst_n(rst_n), .drv_en(drv_en), .drv_data(drv_data), .clr_fault(clr_fault),
        .bus_out(bus3), .conflict(cf3), .fault(ft3), .conflict_cnt(cnt3));

    typedef struct {
        logic [NI-1:0][7:0]  bus;
        logic [NI-1:0][7:0]  conf;
        logic [NI-1:0]       fault;
        logic [NI-1:0][15:0] cnt;
        string               tag;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    int          m_mode [NI] = '{0, 1, 0, 2};
    int          m_pull [NI] = '{0, 1, 1, 0};
    int          m_cmax [NI] = '{65535, 65535, 15, 65535};
    bit          m_fault[NI];
    int          m_consec[NI];
    int          m_cnt  [NI];
    logic [7:0]  m_bus  [NI];
    logic [7:0]  m_conf [NI];

    // Reference: per bit, count enabled drivers and how many of them drive a 1.
    task automatic model_step(input logic r, input logic [3:0] en, input logic [31:0] d, input logic clr);
        for (int k = 0; k < NI; k++) begin
            logic [7:0] rv;
            logic [7:0] mv;
            if (!r) begin
                m_bus[k]    = (m_pull[k] != 0) ? 8'hFF : 8'h00;
                m_conf[k]   = 8'h00;
                m_fault[k]  = 1'b0;
                m_cnt[k]    = 0;
                m_consec[k] = 0;
            end else begin
                for (int b = 0; b < 8; b++) begin
                    int n_en = 0;
                    int ones = 0;
                    for (int i = 0; i < 4; i++) begin
                        if (en[i]) begin
                            n_en++;
                            if (d[i*8 + b]) ones++;
                        end
                    end
                    mv[b] = 1'b0;
                    if (n_en == 0)          rv[b] = (m_pull[k] != 0);
                    else if (m_mode[k] == 2) rv[b] = (ones > 0);
                    else if (m_mode[k] == 1) rv[b] = (ones == n_en);
                    else begin
                        rv[b] = (ones == n_en);
                        mv[b] = (ones != 0) && (ones != n_en);
                    end
                end
                m_conf[k] = mv;
                if (mv != 0 && m_cnt[k] < m_cmax[k]) m_cnt[k]++;
                if (!m_fault[k]) begin
                    m_bus[k]    = rv;
                    m_consec[k] = (mv != 0) ? m_consec[k] + 1 : 0;
                    if (m_consec[k] == THRESH) begin
                        m_fault[k]  = 1'b1;
                        m_consec[k] = 0;
                    end
                end else if (clr) begin
                    m_fault[k]  = 1'b0;
                    m_consec[k] = 0;
                end
            end
        end
    endtask

    task automatic step(input string tag, input logic r, input logic [3:0] en,
                        input logic [31:0] d, input logic clr);
        exp_t e;
        @(negedge clk);
        rst_n     = r;
        drv_en    = en;
        drv_data  = d;
        clr_fault = clr;
        model_step(r, en, d, clr);
        for (int k = 0; k < NI; k++) begin
            e.bus[k]   = m_bus[k];
            e.conf[k]  = m_conf[k];
            e.fault[k] = m_fault[k];
            e.cnt[k]   = 16'(m_cnt[k]);
        end
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input string tag, input int k,
                       input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d step=%s got=%0h exp=%0h", name, k, tag, got, exp);
        end
    endtask

    // Monitor: outputs are presented every cycle, compared 2 time units after each edge.
    initial begin
        exp_t e;
        logic [NI-1:0][7:0]  g_bus;
        logic [NI-1:0][7:0]  g_conf;
        logic [NI-1:0]       g_fault;
        logic [NI-1:0][15:0] g_cnt;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e       = sb.pop_front();
                g_bus   = {bus3, bus2, bus1, bus0};
                g_conf  = {cf3, cf2, cf1, cf0};
                g_fault = {ft3, ft2, ft1, ft0};
                g_cnt   = {cnt3, 16'(cnt2), cnt1, cnt0};
                for (int k = 0; k < NI; k++) begin
                    chk("bus_out",      e.tag, k, 16'(g_bus[k]),   16'(e.bus[k]));
                    chk("conflict",     e.tag, k, 16'(g_conf[k]),  16'(e.conf[k]));
                    chk("fault",        e.tag, k, 16'(g_fault[k]), 16'(e.fault[k]));
                    chk("conflict_cnt", e.tag, k, g_cnt[k],        e.cnt[k]);
                end
            end
        end
    end

    initial begin
        step("reset0", 1'b0, 4'b0000, 32'h0, 1'b0);
        step("reset1", 1'b0, 4'b0000, 32'h0, 1'b0);
        step("tri_single", 1'b1, 4'b0001, 32'h0000_00A5, 1'b0);
        for (int i = 0; i < 3; i++) step("tri_conflict", 1'b1, 4'b0011, 32'h0000_0FF0, 1'b0);
        step("fault_hold", 1'b1, 4'b0011, 32'h0000_0F55, 1'b0);
        step("fault_hold2", 1'b1, 4'b0001, 32'h0000_0033, 1'b0);
        step("clr_pulse", 1'b1, 4'b0011, 32'h0000_0FF0, 1'b1);
        for (int i = 0; i < 4; i++) step("refault", 1'b1, 4'b0011, 32'h0000_0FF0, 1'b0);
        step("clr_in_fault_agree", 1'b1, 4'b0001, 32'h0000_0011, 1'b1);
        step("clr_in_run", 1'b1, 4'b0001, 32'h0000_0022, 1'b1);
        step("wand_all", 1'b1, 4'b1111, 32'hFF3C_F0FF, 1'b0);
        step("none_en", 1'b1, 4'b0000, 32'h1234_5678, 1'b0);
        for (int i = 0; i < 20; i++) step("saturate", 1'b1, 4'b0011, 32'h0000_0FF0, 1'b0);
        step("reset_mid_fault", 1'b0, 4'b0011, 32'h0000_0FF0, 1'b1);
        step("post_reset", 1'b1, 4'b0101, 32'h0077_0077, 1'b0);
        for (int i = 0; i < 2; i++) step("pre_coincide", 1'b1, 4'b0011, 32'h0000_0FF0, 1'b0);
        step("clr_at_thresh", 1'b1, 4'b0011, 32'h0000_0FF0, 1'b1);

        for (int i = 0; i < 400; i++) begin
            logic [7:0]  base;
            logic [31:0] d;
            base = 8'($urandom);
            d    = {4{base}};
            if ($urandom_range(0, 2) == 0) d = d ^ ($urandom & $urandom & $urandom);
            step("random", ($urandom_range(0, 49) != 0), 4'($urandom),
                 d, ($urandom_range(0, 5) == 0));
        end

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
